// File: rtl/shifter_iter.sv
// shifter_iter: multi-cycle shift/rotate unit. It applies at most STEP bit positions per clock.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid, in_ready   - operand handshake; in_ready is high only while idle
//   data_in, amt, op     - operand, unsigned shift amount, operation code
//   out_valid, out_ready - result handshake; out_valid is high only while done
//   data_out, err        - registered result; err is set when the op was illegal
module shifter_iter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             err
);

    // One extra bit so that STEP == WIDTH is representable.
    localparam int unsigned KW = SHW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] data, data_n;
    logic [SHW-1:0]   rem, rem_n;
    logic [2:0]       op_q, op_n;
    logic             err_n;
    logic             in_ready_n, out_valid_n;

    logic [KW-1:0]      k;
    logic [SHW-1:0]     rem_left;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic [WIDTH-1:0]   step_data;

    // Single shift stage: move data by k = min(rem, STEP) for the latched op.
    always_comb begin
        k        = (KW'(rem) < KW'(STEP)) ? KW'(rem) : KW'(STEP);
        rem_left = rem - SHW'(k);
        // Rotates come from a doubled word, so the bits that leave one end wrap in at the other.
        dbl_l    = {data, data} << k;
        dbl_r    = {data, data} >> k;
        case (op_q)
            OP_ROL:  step_data = dbl_l[2*WIDTH-1:WIDTH];
            OP_SLL:  step_data = data << k;
            OP_SRA:  step_data = $signed(data) >>> k;
            OP_SRL:  step_data = data >> k;
            OP_ROR:  step_data = dbl_r[WIDTH-1:0];
            default: step_data = data;
        endcase
    end

    // Next-state and register-input logic.
    always_comb begin
        state_n = state;
        data_n  = data;
        rem_n   = rem;
        op_n    = op_q;
        err_n   = err;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    data_n = data_in;
                    rem_n  = amt;
                    op_n   = op;
                    if (op > OP_ROR) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        err_n   = 1'b0;
                        state_n = (amt == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                data_n = step_data;
                rem_n  = rem_left;
                if (rem_left == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            data      <= '0;
            rem       <= '0;
            op_q      <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            data      <= data_n;
            rem       <= rem_n;
            op_q      <= op_n;
            err       <= err_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
        end
    end

    // The data register is the result register; it does not change while done.
    assign data_out = data;

endmodule
